// File: rtl/shape_processor_mc_pkg.sv
// Shared types and legality helpers for the multi-channel shape control block.
// SHAPE_PROCESSOR_MC_SHADOW_COMMIT_EN enables shadow SFRs with a commit strobe.
package shape_processor_mc_pkg;

  typedef enum logic [2:0] {
    CIRCLE     = 3'd0,
    RECTANGLE  = 3'd1,
    TRIANGLE   = 3'd2,
    KEEP_SHAPE = 3'd7
  } shape_e;

  typedef enum logic [2:0] {
    PERIMETER      = 3'd0,
    AREA           = 3'd1,
    IS_SQUARE      = 3'd2,
    IS_EQUILATERAL = 3'd3,
    IS_ISOSCELES   = 3'd4,
    KEEP_OPERATION = 3'd7
  } operation_e;

  typedef struct packed {
    shape_e     shape;
    operation_e operation;
  } ctrl_sfr_reg;

  localparam int SHAPE_LSB    = 0;
  localparam int OP_LSB       = 8;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CH_LSB  = 24;
  localparam int STAT_CH_W    = 4;

  localparam ctrl_sfr_reg CTRL_RST = '{
    shape:     CIRCLE,
    operation: PERIMETER
  };

  function automatic logic is_reserved_shape(
    input logic [2:0] s
  );
    return (s >= 3'd3) && (s <= 3'd6);
  endfunction

  function automatic logic is_reserved_operation(
    input logic [2:0] o
  );
    return (o == 3'd5) || (o == 3'd6);
  endfunction

  function automatic logic is_legal_combination(
    input logic [2:0] s,
    input logic [2:0] o
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      s == CIRCLE:
        ok = (o == PERIMETER) || (o == AREA);
      s == RECTANGLE:
        ok = (o == PERIMETER) || (o == AREA)
          || (o == IS_SQUARE);
      s == TRIANGLE:
        ok = (o == PERIMETER) || (o == AREA)
          || (o == IS_EQUILATERAL)
          || (o == IS_ISOSCELES);
      default:
        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/shape_processor_ctrl_channel.sv
// One CTRL channel: KEEP resolution, accept/reject and the SFR itself.
// SHAPE_PROCESSOR_MC_SHADOW_COMMIT_EN adds a shadow SFR and commit input.
module shape_processor_ctrl_channel
  import shape_processor_mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [2:0]  wr_shape,
  input  logic [2:0]  wr_op,
`ifdef SHAPE_PROCESSOR_MC_SHADOW_COMMIT_EN
  input  logic        commit,
`endif
  output ctrl_sfr_reg active,
  output ctrl_sfr_reg view,
  output logic        reject
);

  ctrl_sfr_reg base;
  ctrl_sfr_reg eff;
  logic        keep_s;
  logic        keep_o;
  logic        noop;
  logic        ok;
  logic        accept;

  always_comb begin
    keep_s = wr_shape == KEEP_SHAPE;
    keep_o = wr_op == KEEP_OPERATION;
    noop   = keep_s && keep_o;
    eff    = base;
    if (!keep_s) eff.shape = shape_e'(wr_shape);
    if (!keep_o) eff.operation = operation_e'(wr_op);
    ok = !is_reserved_shape(wr_shape)
      && !is_reserved_operation(wr_op)
      && is_legal_combination(eff.shape, eff.operation);
    accept = we && !noop && ok;
    reject = we && !noop && !ok;
  end

`ifdef SHAPE_PROCESSOR_MC_SHADOW_COMMIT_EN
  ctrl_sfr_reg shadow;

  // commit copies the pre-write shadow; a same-cycle write stays pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= CTRL_RST;
      shadow <= CTRL_RST;
    end else begin
      if (commit) active <= shadow;
      if (accept) shadow <= eff;
    end
  end

  assign base = shadow;
  assign view = shadow;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= CTRL_RST;
    end else if (accept) begin
      active <= eff;
    end
  end

  assign base = active;
  assign view = active;
`endif

endmodule

// File: rtl/shape_processor_mc.sv
// Multi-channel shape control: decode, STATUS, read mux and error pulse.
// SHAPE_PROCESSOR_MC_SHADOW_COMMIT_EN adds the commit port.
module shape_processor_mc_ctrl
  import shape_processor_mc_pkg::*;
#(
  parameter  int NUM_CHANNELS = 4,
  parameter  int ERR_CNT_W    = 8,
  localparam int ADDR_W       = $clog2(NUM_CHANNELS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      write,
  input  logic [ADDR_W-1:0]         address,
  input  logic [31:0]               write_data,
  input  logic                      read,
`ifdef SHAPE_PROCESSOR_MC_SHADOW_COMMIT_EN
  input  logic                      commit,
`endif
  output logic [31:0]               read_data,
  output logic                      error,
  output logic [NUM_CHANNELS*3-1:0] ctrl_shape,
  output logic [NUM_CHANNELS*3-1:0] ctrl_operation
);

  localparam logic [ADDR_W-1:0] STATUS_ADDR =
    ADDR_W'(NUM_CHANNELS);

  ctrl_sfr_reg             act  [NUM_CHANNELS];
  ctrl_sfr_reg             view [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] rej;

  logic                    addr_is_ctrl;
  logic                    addr_is_status;
  logic                    ctrl_reject;
  logic                    wr_reject;
  logic                    bad_read;
  logic                    status_rd;
  logic [STAT_CH_W-1:0]    ch_idx;

  logic                    sticky;
  logic [ERR_CNT_W-1:0]    err_cnt;
  logic [STAT_CH_W-1:0]    last_ch;
  logic [31:0]             status_word;
  logic [31:0]             rd_mux;

  assign addr_is_ctrl   = address < STATUS_ADDR;
  assign addr_is_status = address == STATUS_ADDR;
  assign ch_idx         = STAT_CH_W'(address);

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
    logic we;
    assign we = write && (address == ADDR_W'(ch));

    shape_processor_ctrl_channel u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (we),
      .wr_shape (write_data[SHAPE_LSB +: 3]),
      .wr_op    (write_data[OP_LSB +: 3]),
`ifdef SHAPE_PROCESSOR_MC_SHADOW_COMMIT_EN
      .commit   (commit),
`endif
      .active   (act[ch]),
      .view     (view[ch]),
      .reject   (rej[ch])
    );

    assign ctrl_shape[ch*3 +: 3]     = act[ch].shape;
    assign ctrl_operation[ch*3 +: 3] = act[ch].operation;
  end

  assign ctrl_reject = |rej;
  assign wr_reject   = ctrl_reject || (write && !addr_is_ctrl);
  assign bad_read    = read && !addr_is_ctrl && !addr_is_status;
  assign status_rd   = read && addr_is_status;

  always_comb begin
    status_word    = '0;
    status_word[0] = sticky;
    status_word[STAT_CNT_LSB +: ERR_CNT_W] = err_cnt;
    status_word[STAT_CH_LSB +: STAT_CH_W]  = last_ch;
  end

  always_comb begin
    rd_mux = '0;
    if (addr_is_status) rd_mux = status_word;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (address == ADDR_W'(ch)) begin
        rd_mux = {21'b0, view[ch].operation,
                  5'b0, view[ch].shape};
      end
    end
  end

  // a rejection in the same cycle as a STATUS read restarts the record
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky  <= 1'b0;
      err_cnt <= '0;
      last_ch <= '0;
    end else if (wr_reject) begin
      sticky <= 1'b1;
      if (status_rd) begin
        err_cnt <= ERR_CNT_W'(1);
      end else if (!(&err_cnt)) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
      if (ctrl_reject) begin
        last_ch <= ch_idx;
      end else if (status_rd) begin
        last_ch <= '0;
      end
    end else if (status_rd) begin
      sticky  <= 1'b0;
      err_cnt <= '0;
      last_ch <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data <= '0;
      error     <= 1'b0;
    end else begin
      if (read) read_data <= rd_mux;
      error <= wr_reject || bad_read;
    end
  end

endmodule

// File: tb/tb_shape_processor_mc_ctrl.sv
// Table-driven bench with a read-data scoreboard for shape_processor_mc_ctrl.
// Covers SHAPE_PROCESSOR_MC_SHADOW_COMMIT_EN when that macro is defined.
module tb_shape_processor_mc_ctrl;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [2:0]  address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        error;
  logic [11:0] ctrl_shape;
  logic [11:0] ctrl_operation;
`ifdef SHAPE_PROCESSOR_MC_SHADOW_COMMIT_EN
  logic        commit = 1'b0;
`endif

  always #5 clk = ~clk;

  shape_processor_mc_ctrl #(
    .NUM_CHANNELS (NCH),
    .ERR_CNT_W    (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .write          (write),
    .address        (address),
    .write_data     (write_data),
    .read           (read),
`ifdef SHAPE_PROCESSOR_MC_SHADOW_COMMIT_EN
    .commit         (commit),
`endif
    .read_data      (read_data),
    .error          (error),
    .ctrl_shape     (ctrl_shape),
    .ctrl_operation (ctrl_operation)
  );

  typedef struct {
    bit          w;
    bit          r;
    logic [2:0]  a;
    logic [31:0] d;
    bit          e_err;
    logic [31:0] e_rd;
    int          ch;
    logic [2:0]  e_s;
    logic [2:0]  e_o;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [2:0]  m_s[NCH];
  logic [2:0]  m_o[NCH];
  vec_t        tbl[21];

  task automatic chk(string name, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               name, got, exp);
    end
  endtask

  task automatic chk_ctrl(string tag);
    for (int ch = 0; ch < NCH; ch++) begin
      chk($sformatf("%s shape ch%0d", tag, ch),
          32'(ctrl_shape[ch*3 +: 3]), 32'(m_s[ch]));
      chk($sformatf("%s op ch%0d", tag, ch),
          32'(ctrl_operation[ch*3 +: 3]), 32'(m_o[ch]));
    end
  endtask

  task automatic step(bit w, bit r, logic [2:0] a,
                      logic [31:0] d, bit e_err,
                      logic [31:0] e_rd, string tag);
    @(negedge clk);
    write = w;
    read = r;
    address = a;
    write_data = d;
    if (r) exp_q.push_back(e_rd);
    @(posedge clk);
    #1;
    write = 1'b0;
    read = 1'b0;
    chk({tag, " error"}, 32'(error), 32'(e_err));
    if (r) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s scoreboard empty", tag);
      end else begin
        chk({tag, " read_data"}, read_data, exp_q.pop_front());
      end
    end
`ifdef SHAPE_PROCESSOR_MC_SHADOW_COMMIT_EN
    if (w) begin
      @(negedge clk);
      commit = 1'b1;
      @(posedge clk);
      #1;
      commit = 1'b0;
    end
`endif
    chk_ctrl(tag);
  endtask

  initial begin
    tbl[0]  = '{1, 0, 3'd1, 32'h102, 0, 0, 1, 3'd2, 3'd1};
    tbl[1]  = '{0, 1, 3'd1, 32'h0, 0, 32'h102, -1, 0, 0};
    tbl[2]  = '{1, 0, 3'd0, 32'h207, 1, 0, -1, 0, 0};
    tbl[3]  = '{0, 1, 3'd4, 32'h0, 0, 32'h101, -1, 0, 0};
    tbl[4]  = '{0, 1, 3'd4, 32'h0, 0, 32'h0, -1, 0, 0};
    tbl[5]  = '{1, 0, 3'd2, 32'h101, 0, 0, 2, 3'd1, 3'd1};
    tbl[6]  = '{1, 0, 3'd2, 32'h707, 0, 0, -1, 0, 0};
    tbl[7]  = '{1, 0, 3'd2, 32'h701, 0, 0, -1, 0, 0};
    tbl[8]  = '{1, 0, 3'd2, 32'h205, 1, 0, -1, 0, 0};
    tbl[9]  = '{0, 1, 3'd4, 32'h0, 0, 32'h0200_0101, -1, 0, 0};
    tbl[10] = '{1, 0, 3'd5, 32'h0, 1, 0, -1, 0, 0};
    tbl[11] = '{0, 1, 3'd4, 32'h0, 0, 32'h101, -1, 0, 0};
    tbl[12] = '{0, 1, 3'd5, 32'h0, 1, 32'h0, -1, 0, 0};
    tbl[13] = '{1, 0, 3'd3, 32'h402, 0, 0, 3, 3'd2, 3'd4};
    tbl[14] = '{1, 0, 3'd3, 32'h007, 0, 0, 3, 3'd2, 3'd0};
    tbl[15] = '{1, 0, 3'd0, 32'h600, 1, 0, -1, 0, 0};
    tbl[16] = '{1, 0, 3'd1, 32'h200, 1, 0, -1, 0, 0};
    tbl[17] = '{1, 1, 3'd1, 32'h001, 0, 32'h102, 1, 3'd1, 3'd0};
    tbl[18] = '{0, 1, 3'd1, 32'h0, 0, 32'h001, -1, 0, 0};
    tbl[19] = '{0, 1, 3'd4, 32'h0, 0, 32'h0100_0201, -1, 0, 0};
    tbl[20] = '{1, 0, 3'd4, 32'h0, 1, 0, -1, 0, 0};

    for (int ch = 0; ch < NCH; ch++) begin
      m_s[ch] = 3'd0;
      m_o[ch] = 3'd0;
    end

    repeat (2) @(posedge clk);
    #1;
    chk_ctrl("reset");
    chk("reset read_data", read_data, 32'h0);
    chk("reset error", 32'(error), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      if (tbl[i].ch >= 0) begin
        m_s[tbl[i].ch] = tbl[i].e_s;
        m_o[tbl[i].ch] = tbl[i].e_o;
      end
      step(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d,
           tbl[i].e_err, tbl[i].e_rd,
           $sformatf("vec%0d", i));
    end

    // counter saturation: 300 illegal writes to ch3
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      write = 1'b1;
      address = 3'd3;
      write_data = 32'h207;
    end
    @(posedge clk);
    #1;
    write = 1'b0;
    chk("sat error", 32'(error), 32'h1);
    step(0, 1, 3'd4, 0, 0, 32'h0300_FF01, "sat status");
    step(1, 0, 3'd3, 32'h207, 1, 0, "pre coincide");
    step(1, 1, 3'd4, 0, 1, 32'h0300_0101, "coincide");
    step(0, 1, 3'd4, 0, 0, 32'h0000_0101, "after coincide");
    step(0, 1, 3'd4, 0, 0, 32'h0, "status clear");

    // reset mid-transaction discards the write and clears all state
    @(negedge clk);
    write = 1'b1;
    address = 3'd2;
    write_data = 32'h102;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    write = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      m_s[ch] = 3'd0;
      m_o[ch] = 3'd0;
    end
    chk_ctrl("mid reset");
    chk("mid reset read_data", read_data, 32'h0);
    chk("mid reset error", 32'(error), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 3'd4, 0, 0, 32'h0, "post reset status");
    step(0, 1, 3'd2, 0, 0, 32'h0, "post reset ch2");

`ifdef SHAPE_PROCESSOR_MC_SHADOW_COMMIT_EN
    @(negedge clk);
    write = 1'b1;
    address = 3'd0;
    write_data = 32'h101;
    @(posedge clk);
    #1;
    write = 1'b0;
    chk_ctrl("shadow pending");
    step(0, 1, 3'd0, 0, 0, 32'h101, "shadow read");
    @(negedge clk);
    commit = 1'b1;
    @(posedge clk);
    #1;
    commit = 1'b0;
    m_s[0] = 3'd1;
    m_o[0] = 3'd1;
    chk_ctrl("commit");
    @(negedge clk);
    write = 1'b1;
    address = 3'd1;
    write_data = 32'h102;
    @(posedge clk);
    #1;
    write = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    commit = 1'b1;
    @(posedge clk);
    #1;
    commit = 1'b0;
    m_s[0] = 3'd0;
    m_o[0] = 3'd0;
    chk_ctrl("shadow reset");
    step(0, 1, 3'd1, 0, 0, 32'h0, "shadow reset read");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shape_processor_mc_ctrl.md
Name: shape_processor_mc_ctrl

Overview:
- Multi-channel successor to the single-SFR shape processor control logic. Holds NUM_CHANNELS independent CTRL SFRs (SHAPE + OPERATION fields) behind one register bus.
- Each write has KEEP_* resolution and reserved-value and legality filtering. Rejected writes are reported through a pulsed error output and a read-to-clear STATUS register.
- Sits between the bus slave and the per-channel shape datapaths.

Parameters:
- NUM_CHANNELS, 4, number of CTRL SFRs; range 1..16.
- ERR_CNT_W, 8, width of saturating rejected-write counter in STATUS.
- ADDR_W, $clog2(NUM_CHANNELS+1), derived; not for override.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- write  in  1  write strobe, single-cycle.
- address  in  ADDR_W  register index: 0..NUM_CHANNELS-1 = CTRL[ch], NUM_CHANNELS = STATUS.
- write_data  in  32  CTRL encoding: SHAPE [2:0], OPERATION [10:8], other bits ignored.
- read  in  1  read strobe.
- read_data  out  32  read return, 1-cycle latency.
- error  out  1  one-cycle pulse, the cycle after a rejected access.
- ctrl_shape  out  NUM_CHANNELS*3  active SHAPE per channel, flattened.
- ctrl_operation  out  NUM_CHANNELS*3  active OPERATION per channel, flattened.

Behaviour:
- Reset is asynchronous and active-low. All CTRL = {CIRCLE, PERIMETER}, read_data = 0, error = 0, STATUS = 0. Asserting reset mid-transaction discards the transaction.
- Encodings:
  - SHAPE: CIRCLE=0, RECTANGLE=1, TRIANGLE=2, 3..6 reserved, KEEP_SHAPE=7.
  - OPERATION: PERIMETER=0, AREA=1, IS_SQUARE=2, IS_EQUILATERAL=3, IS_ISOSCELES=4, 5..6 reserved, KEEP_OPERATION=7.
- Legal combinations:
  - CIRCLE: {PERIMETER, AREA}.
  - RECTANGLE: {PERIMETER, AREA, IS_SQUARE}.
  - TRIANGLE: {PERIMETER, AREA, IS_EQUILATERAL, IS_ISOSCELES}.
- CTRL write: resolve KEEP_* against the current channel value to get the effective pair.
  - Accept only if no field is reserved, the effective pair is legal, and KEEP_SHAPE and KEEP_OPERATION are not both set.
  - Accepted: the SFR updates at the next edge.
  - Rejected: the SFR is fully stable; error pulses the next cycle.
- A write of KEEP_SHAPE+KEEP_OPERATION is a legal no-op: no update, no error.
- Write to STATUS or to an out-of-range address: ignored, error pulses.
- Read: read_data is valid the cycle after read, and holds until the next read.
  - CTRL reads return {21'b0, op, 5'b0, shape}.
  - Out-of-range reads return 0 and pulse error.
- STATUS layout: [0] sticky error, [ERR_CNT_W+7:8] rejected count saturating at all-ones, [27:24] channel of last rejected CTRL write.
- A STATUS read returns the current value, then clears it. If a rejection occurs in the same cycle as the STATUS read, the new event wins: sticky=1, count=1, channel updated.
- Simultaneous write and read of the same CTRL: read_data returns the pre-write value.
- Channels never affect each other. Without a write, no SFR changes.

Optional Feature:
- Macro: SHAPE_PROCESSOR_MC_SHADOW_COMMIT_EN.
- Enabled:
  - Adds input commit (1 bit).
  - Accepted writes go to per-channel shadow SFRs. KEEP_* and legality resolve against the shadow.
  - ctrl_* outputs show the active SFRs. commit copies all shadows to active at the next edge.
  - Commit and write in the same cycle: commit copies the pre-write shadows; the write stays pending.
  - CTRL reads return the shadow.
- Disabled: no commit port; accepted writes update the active SFRs directly.

Decomposition:
- Package shape_processor_mc_pkg holds:
  - shape_e and operation_e (including KEEP_*).
  - ctrl_sfr_reg packed struct.
  - Field bit positions.
  - Functions is_reserved_shape, is_reserved_operation, is_legal_combination.
- Sub-module shape_processor_ctrl_channel: one channel's SFR (plus shadow when enabled), KEEP resolution and accept/reject decision. Generated NUM_CHANNELS times.
- The top level holds address decode, STATUS/counter, the read mux and the error register.

Test Plan:
- Write ch1 0x0000_0102 -> ctrl ch1 = {TRIANGLE, AREA} next cycle; read ch1 -> 0x0000_0102; error stays 0.
- Ch0 reset {CIRCLE, PERIMETER}, write 0x0000_0207 (KEEP_SHAPE, IS_SQUARE) -> rejected, ch0 unchanged, error pulse; STATUS read = 0x0000_0101 | (0<<24), a second read = 0.
- Ch2 = {RECTANGLE, AREA}, write 0x0000_0707 -> no change, no error. Then write 0x0000_0701 -> no change. Then write 0x0000_0205 -> reserved shape, rejected.
- 300 rejected writes to ch3 -> STATUS count = 0xFF, channel field = 3. STATUS read coinciding with a rejection -> next STATUS count = 1.
- Read STATUS with NUM_CHANNELS=4 at address 4 after an address-5 write -> sticky=1; address-5 read returns 0 with an error pulse.
- With SHADOW_COMMIT_EN: write ch0 0x0000_0101 -> ctrl ch0 still {CIRCLE, PERIMETER}; commit -> {RECTANGLE, AREA} next cycle. Reset asserted mid-pending clears the shadow.
